// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and op-decode helpers for the iterative RV32M multiply/divide sequencer.
package muldiv_unit_pkg;

   // funct7 value that routes an R-type op to this unit (ALU_OP_R_MULDIV decode hook)
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      MULDIV_MUL    = 3'b000,
      MULDIV_MULH   = 3'b001,
      MULDIV_MULHSU = 3'b010,
      MULDIV_MULHU  = 3'b011,
      MULDIV_DIV    = 3'b100,
      MULDIV_DIVU   = 3'b101,
      MULDIV_REM    = 3'b110,
      MULDIV_REMU   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   function automatic logic op_is_div(input md_op_e op);
      return op inside {MULDIV_DIV, MULDIV_DIVU, MULDIV_REM, MULDIV_REMU};
   endfunction

   function automatic logic op_a_signed(input md_op_e op);
      return op inside {MULDIV_MUL, MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
   endfunction

   function automatic logic op_b_signed(input md_op_e op);
      return op inside {MULDIV_MUL, MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
   endfunction

   // Result comes from the hi register (product high half / remainder) rather than lo.
   function automatic logic op_takes_high(input md_op_e op);
      return op inside {MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU, MULDIV_REM, MULDIV_REMU};
   endfunction

endpackage

// File: rtl/muldiv_unit_cla.sv
// Generate/propagate adder-subtractor shared by every arithmetic step of the sequencer.
module muldiv_unit_cla #(
   parameter int WIDTH = 33
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub_en,
   output logic [WIDTH-1:0] sum
);

   logic [WIDTH-1:0] y_eff;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] c;

   // NOTE: every always_comb output is assigned on all paths before use, so no latch is inferred.
   always_comb begin
      y_eff = sub_en ? ~y : y;
      g     = x & y_eff;
      p     = x ^ y_eff;
      c[0]  = sub_en;
      for (int i = 1; i < WIDTH; i++) begin
         c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
      sum = p ^ c;
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide, WIDTH steps,
// one shared adder; stalls the pipe while busy and pulses done with the result.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   md_state_e        state, state_nxt;
   md_op_e           op_q, op_in;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] hi, lo, opnd, result_q;
   logic             opnd_neg, res_neg;

   logic [WIDTH:0]   add_x, add_y, add_sum, opnd_ext, rem_shift, mul_t;
   logic             add_sub;
   logic             a_neg, b_neg, div_in, special, accept, last_step, high_mul;
   logic [WIDTH-1:0] sel_val, mag_in, final_val;

   assign op_in     = md_op_e'(funct3);
   assign last_step = (cnt == CNT_W'(WIDTH - 1));

   // The non-magnitude operand stays raw; adding |x| becomes x+v or v-x depending on its sign.
   always_comb begin
      a_neg     = op_a_signed(op_in) & a[WIDTH-1];
      b_neg     = op_b_signed(op_in) & b[WIDTH-1];
      div_in    = op_is_div(op_in);
      special   = div_in & ((b == '0) | (op_b_signed(op_in) & (a == INT_MIN) & (b == '1)));
      opnd_ext  = {opnd_neg, opnd};
      rem_shift = {hi, lo[WIDTH-1]};
      sel_val   = op_takes_high(op_q) ? hi : lo;
      high_mul  = !op_is_div(op_q) && (op_q != MULDIV_MUL);
      add_x     = '0;
      add_y     = '0;
      add_sub   = 1'b0;
      unique case (state)
         MD_IDLE: begin
            add_y   = {1'b0, div_in ? a : b};
            add_sub = 1'b1;
         end
         MD_CALC: begin
            add_y = opnd_ext;
            if (op_is_div(op_q)) begin
               add_x   = rem_shift;
               add_sub = ~opnd_neg;
            end else begin
               add_x   = {1'b0, hi};
               add_sub = opnd_neg;
            end
         end
         MD_DONE: begin
            // High half of a negated product is ~hi, plus one only when the low half is zero.
            add_x   = (high_mul && (lo != '0)) ? '1 : '0;
            add_y   = {1'b0, sel_val};
            add_sub = 1'b1;
         end
         default: ;
      endcase
   end

   muldiv_unit_cla #(.WIDTH(WIDTH + 1)) u_cla (
      .x      (add_x),
      .y      (add_y),
      .sub_en (add_sub),
      .sum    (add_sum)
   );

   always_comb begin
      mag_in    = (div_in ? a_neg : b_neg) ? add_sum[WIDTH-1:0] : (div_in ? a : b);
      mul_t     = lo[0] ? add_sum : {1'b0, hi};
      final_val = res_neg ? add_sum[WIDTH-1:0] : sel_val;
   end

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      unique case (state)
         MD_IDLE: begin
            if (start && !flush) begin
               accept    = 1'b1;
               stall     = 1'b1;
               state_nxt = special ? MD_DONE : MD_CALC;
            end
         end
         MD_CALC: begin
            stall = 1'b1;
            if (last_step) state_nxt = MD_CALC == MD_CALC ? MD_DONE : MD_CALC;
         end
         MD_DONE: begin
            done      = 1'b1;
            state_nxt = MD_IDLE;
         end
         default: state_nxt = MD_IDLE;
      endcase
      if (flush) begin
         state_nxt = MD_IDLE;
         done      = 1'b0;
      end
   end

   // The done-cycle value is forwarded so it is visible with the pulse; result_q holds it afterwards.
   assign result = done ? final_val : result_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= MD_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= MULDIV_MUL;
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         opnd     <= '0;
         opnd_neg <= 1'b0;
         res_neg  <= 1'b0;
         result_q <= '0;
      end else begin
         if (accept) begin
            op_q     <= op_in;
            cnt      <= '0;
            opnd     <= div_in ? b : a;
            opnd_neg <= div_in ? b_neg : a_neg;
            res_neg  <= special ? 1'b0 : ((op_in == MULDIV_REM) ? a_neg : (a_neg ^ b_neg));
            if (special) begin
               hi <= (b == '0) ? a : '0;
               lo <= (b == '0) ? '1 : a;
            end else begin
               hi <= '0;
               lo <= mag_in;
            end
         end else if (state == MD_CALC) begin
            cnt <= cnt + CNT_W'(1);
            if (op_is_div(op_q)) begin
               // A non-negative trial difference keeps the subtraction and sets the quotient bit.
               hi <= add_sum[WIDTH] ? rem_shift[WIDTH-1:0] : add_sum[WIDTH-1:0];
               lo <= {lo[WIDTH-2:0], ~add_sum[WIDTH]};
            end else begin
               hi <= mul_t[WIDTH:1];
               lo <= {mul_t[0], lo[WIDTH-1:1]};
            end
         end
         if (done) result_q <= final_val;
      end
   end

endmodule
